// File: rtl/pwm_multi_servo_if.sv
// Command channel between the UART front end and pwm_multi_servo.
// Handshake: a command transfers on any clk edge where cmd_valid && cmd_ready;
// cmd_ch/cmd_level must be stable while cmd_valid is high; cmd_err answers one cycle later.
interface pwm_multi_servo_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_ch;
    logic [7:0] cmd_level;
    logic       cmd_err;

    modport master (output cmd_valid, cmd_ch, cmd_level, input cmd_ready, cmd_err);
    modport slave  (input cmd_valid, cmd_ch, cmd_level, output cmd_ready, cmd_err);
endinterface

// File: rtl/pwm_multi_servo.sv
// N-channel servo PWM with per-channel ramped targets set by UART commands or buttons.
// Optional macro PWM_STAGGER_EN spreads channel rising edges across the frame.
module pwm_multi_servo #(
    parameter int NUM_CH      = 4,
    parameter int LEVELS      = 8,
    parameter int PERIOD_CYC  = 540000,
    parameter int MIN_PULSE   = 27000,
    parameter int STEP_PULSE  = 3857,
    parameter int RAMP_FRAMES = 4,
    parameter int HOME_LEVEL  = 0,
    localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up,
    input  logic              down,
    input  logic [CW-1:0]     btn_ch,
    pwm_multi_servo_if.slave  cmd,
    output logic [NUM_CH-1:0] pwm,
    output logic [NUM_CH-1:0] target_reached,
    output logic [NUM_CH-1:0] moving,
    output logic [NUM_CH-1:0] reached_strobe
);
    localparam int CNTW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int RW   = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
`ifdef PWM_STAGGER_EN
    localparam int STAG = PERIOD_CYC / NUM_CH;
`endif

    logic [CNTW-1:0]   frame_cnt;
    logic [RW-1:0]     ramp_div;
    logic              frame_tick;
    logic              ramp_step;
    logic [LW-1:0]     cur      [NUM_CH];
    logic [LW-1:0]     tgt      [NUM_CH];
    logic [LW-1:0]     tgt_next [NUM_CH];
    logic [NUM_CH-1:0] at_tgt;
    logic [NUM_CH-1:0] pwm_next;

    logic [1:0] up_sync;
    logic [1:0] dn_sync;
    logic       up_prev;
    logic       dn_prev;
    logic       up_edge;
    logic       dn_edge;

    logic          cmd_fire;
    logic          ch_bad;
    logic          lvl_clip;
    logic [LW-1:0] lvl_val;
    logic          btn_ok;

    function automatic logic [31:0] pulse_of(input logic [LW-1:0] lvl);
        return 32'(MIN_PULSE) + 32'(lvl) * 32'(STEP_PULSE);
    endfunction

    assign frame_tick = (32'(frame_cnt) == 32'(PERIOD_CYC - 1));
    assign ramp_step  = frame_tick && (32'(ramp_div) == 32'(RAMP_FRAMES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            ramp_div  <= '0;
        end else if (frame_tick) begin
            frame_cnt <= '0;
            ramp_div  <= (32'(ramp_div) == 32'(RAMP_FRAMES - 1)) ? '0 : ramp_div + 1'b1;
        end else begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Raw buttons are asynchronous: two flops, then a registered copy for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            up_sync <= '0;
            dn_sync <= '0;
            up_prev <= 1'b0;
            dn_prev <= 1'b0;
        end else begin
            up_sync <= {up_sync[0], up};
            dn_sync <= {dn_sync[0], down};
            up_prev <= up_sync[1];
            dn_prev <= dn_sync[1];
        end
    end

    assign up_edge = up_sync[1] & ~up_prev;
    assign dn_edge = dn_sync[1] & ~dn_prev;

    assign cmd_fire = cmd.cmd_valid & cmd.cmd_ready;
    assign ch_bad   = (32'(cmd.cmd_ch) >= 32'(NUM_CH));
    assign lvl_clip = (32'(cmd.cmd_level) >= 32'(LEVELS));
    assign lvl_val  = lvl_clip ? LW'(LEVELS - 1) : cmd.cmd_level[LW-1:0];
    assign btn_ok   = (32'(btn_ch) < 32'(NUM_CH));

    // A command to a channel masks a button event on that same channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            tgt_next[i] = tgt[i];
            if (cmd_fire && !ch_bad && (32'(cmd.cmd_ch) == 32'(i))) begin
                tgt_next[i] = lvl_val;
            end else if (btn_ok && (32'(btn_ch) == 32'(i))) begin
                if (up_edge && !dn_edge && (32'(tgt[i]) < 32'(LEVELS - 1))) begin
                    tgt_next[i] = tgt[i] + 1'b1;
                end else if (dn_edge && !up_edge && (tgt[i] != '0)) begin
                    tgt_next[i] = tgt[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic [31:0] phase;
        phase    = '0;
        pwm_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef PWM_STAGGER_EN
            phase = 32'(frame_cnt) + 32'(PERIOD_CYC) - 32'(i * STAG);
            if (phase >= 32'(PERIOD_CYC)) phase = phase - 32'(PERIOD_CYC);
`else
            phase = 32'(frame_cnt);
`endif
            pwm_next[i] = (phase < pulse_of(cur[i]));
        end
    end

    always_comb begin
        at_tgt = '0;
        for (int i = 0; i < NUM_CH; i++) at_tgt[i] = (cur[i] == tgt[i]);
    end

    // cur moves only on frame boundaries so a running pulse is never cut short.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cur[i] <= LW'(HOME_LEVEL);
                tgt[i] <= LW'(HOME_LEVEL);
            end
            pwm            <= '0;
            target_reached <= '1;
            reached_strobe <= '0;
            cmd.cmd_err    <= 1'b0;
            cmd.cmd_ready  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                tgt[i] <= tgt_next[i];
                if (ramp_step && (cur[i] != tgt[i])) begin
                    cur[i] <= (cur[i] < tgt[i]) ? cur[i] + 1'b1 : cur[i] - 1'b1;
                end
            end
            pwm            <= pwm_next;
            target_reached <= at_tgt;
            reached_strobe <= at_tgt & ~target_reached;
            cmd.cmd_err    <= cmd_fire & (ch_bad | lvl_clip);
            cmd.cmd_ready  <= 1'b1;
        end
    end

    assign moving = ~target_reached;
endmodule

// File: tb/tb_pwm_multi_servo.sv
// Directed self-checking bench for pwm_multi_servo (default build, small frame parameters).
module tb_pwm_multi_servo;
    localparam int NUM_CH = 4;
    localparam int PERIOD_CYC = 100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              up = 1'b0;
    logic              down = 1'b0;
    logic [1:0]        btn_ch = 2'd0;
    logic [NUM_CH-1:0] pwm;
    logic [NUM_CH-1:0] target_reached;
    logic [NUM_CH-1:0] moving;
    logic [NUM_CH-1:0] reached_strobe;

    pwm_multi_servo_if cmd_if ();

    int n_checks = 0;
    int n_fail   = 0;
    int width      [NUM_CH];
    int strobe_cnt [NUM_CH];
    logic [7:0] exp_q [$];

    pwm_multi_servo #(
        .NUM_CH(4), .LEVELS(8), .PERIOD_CYC(100), .MIN_PULSE(10),
        .STEP_PULSE(5), .RAMP_FRAMES(1), .HOME_LEVEL(0)
    ) dut (
        .clk(clk), .rst(rst), .up(up), .down(down), .btn_ch(btn_ch),
        .cmd(cmd_if), .pwm(pwm), .target_reached(target_reached),
        .moving(moving), .reached_strobe(reached_strobe)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < NUM_CH; i++) strobe_cnt[i] = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < NUM_CH; i++) if (reached_strobe[i] === 1'b1) strobe_cnt[i] <= strobe_cnt[i] + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no end, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic wait_cnt(input int v);
        int k = 0;
        while ((32'(dut.frame_cnt) != 32'(v)) && (k < 300)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            n_checks++; n_fail++;
            $display("FAIL wait_cnt: counter got %0d expected %0d", dut.frame_cnt, v);
        end
    endtask

    task automatic wait_cur(input int ch, input int lvl);
        int k = 0;
        while ((32'(dut.cur[ch]) != 32'(lvl)) && (k < 1500)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1500) begin
            n_checks++; n_fail++;
            $display("FAIL wait_cur: cur[%0d] got %0d expected %0d", ch, dut.cur[ch], lvl);
        end
    endtask

    // Counts high cycles of one whole frame; pwm lags the counter by one cycle.
    task automatic measure_frame();
        wait_cnt(1);
        for (int c = 0; c < NUM_CH; c++) width[c] = 0;
        for (int k = 0; k < PERIOD_CYC; k++) begin
            for (int c = 0; c < NUM_CH; c++) if (pwm[c] === 1'b1) width[c]++;
            @(negedge clk);
        end
    endtask

    task automatic send_cmd(input int ch, input int lvl);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ch    = 8'(ch);
        cmd_if.cmd_level = 8'(lvl);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic press(input logic u, input logic d);
        up = u; down = d;
        repeat (4) @(negedge clk);
        up = 1'b0; down = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (cmd_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", cmd_if.cmd_ready); end
        n_checks++; if (pwm !== 4'b0000) begin n_fail++; $display("FAIL rst_pwm: got %b expected 0000", pwm); end
        n_checks++; if (target_reached !== 4'b1111) begin n_fail++; $display("FAIL rst_reached: got %b expected 1111", target_reached); end
        n_checks++; if (moving !== 4'b0000) begin n_fail++; $display("FAIL rst_moving: got %b expected 0000", moving); end
        n_checks++; if (reached_strobe !== 4'b0000) begin n_fail++; $display("FAIL rst_strobe: got %b expected 0000", reached_strobe); end
        n_checks++; if (cmd_if.cmd_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", cmd_if.cmd_err); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_rst: got %b expected 1", cmd_if.cmd_ready); end
        measure_frame();
        n_checks++; if (width[0] != 10) begin n_fail++; $display("FAIL home_width0: got %0d expected 10", width[0]); end
        n_checks++; if (width[3] != 10) begin n_fail++; $display("FAIL home_width3: got %0d expected 10", width[3]); end
    endtask

    task automatic test_single_cmd();
        int s0;
        logic [7:0] e;
        s0 = strobe_cnt[2];
        wait_cnt(50);
        send_cmd(2, 3);
        n_checks++; if (cmd_if.cmd_err !== 1'b0) begin n_fail++; $display("FAIL cmd_ok_err: got %b expected 0", cmd_if.cmd_err); end
        @(negedge clk);
        n_checks++; if (moving[2] !== 1'b1) begin n_fail++; $display("FAIL moving2: got %b expected 1", moving[2]); end
        exp_q.push_back(8'd15); exp_q.push_back(8'd20); exp_q.push_back(8'd25);
        for (int f = 0; f < 3; f++) begin
            measure_frame();
            e = exp_q.pop_front();
            n_checks++; if (width[2] != int'(e)) begin n_fail++; $display("FAIL ramp_width2 f%0d: got %0d expected %0d", f, width[2], e); end
        end
        n_checks++; if (width[0] != 10 || width[1] != 10) begin n_fail++; $display("FAIL other_widths: got %0d/%0d expected 10/10", width[0], width[1]); end
        n_checks++; if (target_reached[2] !== 1'b1) begin n_fail++; $display("FAIL reached2: got %b expected 1", target_reached[2]); end
        n_checks++; if (strobe_cnt[2] != s0 + 1) begin n_fail++; $display("FAIL strobe2: got %0d expected %0d", strobe_cnt[2], s0 + 1); end
    endtask

    task automatic test_cmd_err();
        int s1;
        wait_cnt(50);
        send_cmd(5, 1);
        n_checks++; if (cmd_if.cmd_err !== 1'b1) begin n_fail++; $display("FAIL bad_ch_err: got %b expected 1", cmd_if.cmd_err); end
        @(negedge clk);
        n_checks++; if (cmd_if.cmd_err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b expected 0", cmd_if.cmd_err); end
        n_checks++; if (dut.tgt[1] !== 3'd0 || dut.tgt[2] !== 3'd3) begin n_fail++; $display("FAIL bad_ch_tgt: got %0d/%0d expected 0/3", dut.tgt[1], dut.tgt[2]); end
        s1 = strobe_cnt[1];
        wait_cnt(50);
        send_cmd(1, 200);
        n_checks++; if (cmd_if.cmd_err !== 1'b1) begin n_fail++; $display("FAIL clip_err: got %b expected 1", cmd_if.cmd_err); end
        n_checks++; if (dut.tgt[1] !== 3'd7) begin n_fail++; $display("FAIL clip_tgt: got %0d expected 7", dut.tgt[1]); end
        for (int f = 0; f < 7; f++) begin
            measure_frame();
            if (f == 0) begin
                n_checks++; if (width[1] != 15) begin n_fail++; $display("FAIL clip_first_width: got %0d expected 15", width[1]); end
            end
        end
        n_checks++; if (width[1] != 45) begin n_fail++; $display("FAIL clip_final_width: got %0d expected 45", width[1]); end
        n_checks++; if (strobe_cnt[1] != s1 + 1) begin n_fail++; $display("FAIL strobe1: got %0d expected %0d", strobe_cnt[1], s1 + 1); end
    endtask

    task automatic test_buttons();
        btn_ch = 2'd3;
        up = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (dut.tgt[3] !== 3'd0) begin n_fail++; $display("FAIL btn_latency_early: got %0d expected 0", dut.tgt[3]); end
        @(negedge clk);
        n_checks++; if (dut.tgt[3] !== 3'd1) begin n_fail++; $display("FAIL btn_latency: got %0d expected 1", dut.tgt[3]); end
        up = 1'b0;
        repeat (4) @(negedge clk);
        for (int p = 0; p < 8; p++) press(1'b1, 1'b0);
        n_checks++; if (dut.tgt[3] !== 3'd7) begin n_fail++; $display("FAIL btn_saturate: got %0d expected 7", dut.tgt[3]); end
        press(1'b1, 1'b1);
        n_checks++; if (dut.tgt[3] !== 3'd7) begin n_fail++; $display("FAIL btn_both: got %0d expected 7", dut.tgt[3]); end
        press(1'b0, 1'b1);
        n_checks++; if (dut.tgt[3] !== 3'd6) begin n_fail++; $display("FAIL btn_down: got %0d expected 6", dut.tgt[3]); end
    endtask

    task automatic test_cmd_vs_button();
        int s0;
        btn_ch = 2'd0;
        down = 1'b1;
        repeat (2) @(negedge clk);
        send_cmd(0, 5);
        down = 1'b0;
        n_checks++; if (dut.tgt[0] !== 3'd5) begin n_fail++; $display("FAIL same_ch_cmd_wins: got %0d expected 5", dut.tgt[0]); end
        repeat (4) @(negedge clk);
        btn_ch = 2'd3;
        down = 1'b1;
        repeat (2) @(negedge clk);
        send_cmd(1, 2);
        down = 1'b0;
        n_checks++; if (dut.tgt[1] !== 3'd2 || dut.tgt[3] !== 3'd5) begin n_fail++; $display("FAIL diff_ch_both: got %0d/%0d expected 2/5", dut.tgt[1], dut.tgt[3]); end
        repeat (4) @(negedge clk);
        wait_cur(0, 3);
        wait_cnt(50);
        s0 = strobe_cnt[0];
        send_cmd(0, 1);
        measure_frame();
        n_checks++; if (width[0] != 20) begin n_fail++; $display("FAIL reverse_w1: got %0d expected 20", width[0]); end
        measure_frame();
        n_checks++; if (width[0] != 15) begin n_fail++; $display("FAIL reverse_w2: got %0d expected 15", width[0]); end
        n_checks++; if (target_reached[0] !== 1'b1 || strobe_cnt[0] != s0 + 1) begin n_fail++; $display("FAIL reverse_strobe: got %b/%0d expected 1/%0d", target_reached[0], strobe_cnt[0], s0 + 1); end
    endtask

    task automatic test_back_to_back();
        int s2;
        s2 = strobe_cnt[2];
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_ch = 8'd2; cmd_if.cmd_level = 8'd3;
        @(negedge clk);
        cmd_if.cmd_ch = 8'd0; cmd_if.cmd_level = 8'd4;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        n_checks++; if (cmd_if.cmd_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b expected 0", cmd_if.cmd_err); end
        repeat (3) @(negedge clk);
        n_checks++; if (dut.tgt[2] !== 3'd3 || dut.tgt[0] !== 3'd4) begin n_fail++; $display("FAIL b2b_tgt: got %0d/%0d expected 3/4", dut.tgt[2], dut.tgt[0]); end
        n_checks++; if (target_reached[2] !== 1'b1 || strobe_cnt[2] != s2) begin n_fail++; $display("FAIL stationary_no_strobe: got %b/%0d expected 1/%0d", target_reached[2], strobe_cnt[2], s2); end
        n_checks++; if (moving[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_moving0: got %b expected 1", moving[0]); end
    endtask

    task automatic test_reset_mid_ramp();
        int s2;
        send_cmd(2, 6);
        wait_cur(2, 5);
        repeat (10) @(negedge clk);
        s2 = strobe_cnt[2];
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (dut.cur[2] !== 3'd0 || dut.tgt[2] !== 3'd0) begin n_fail++; $display("FAIL mid_rst_levels: got %0d/%0d expected 0/0", dut.cur[2], dut.tgt[2]); end
        n_checks++; if (pwm !== 4'b0000 || cmd_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_outputs: got %b/%b expected 0000/0", pwm, cmd_if.cmd_ready); end
        n_checks++; if (target_reached !== 4'b1111 || reached_strobe !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_status: got %b/%b expected 1111/0000", target_reached, reached_strobe); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (strobe_cnt[2] != s2 || target_reached !== 4'b1111) begin n_fail++; $display("FAIL mid_rst_no_strobe: got %0d/%b expected %0d/1111", strobe_cnt[2], target_reached, s2); end
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_ch    = 8'd0;
        cmd_if.cmd_level = 8'd0;
        test_reset();
        test_single_cmd();
        test_cmd_err();
        test_buttons();
        test_cmd_vs_button();
        test_back_to_back();
        test_reset_mid_ramp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
